// File: rtl/arith_pkg.sv
// ---------------------------------------------------------------------------
// arith_pkg
//
// Shared definitions for the arithmetic unit: the sequential multiplier and
// the restoring divider use the same start/valid handshake and the same
// three-state controller shape, so their encodings live side by side here.
//
// Contents:
//   DEFAULT_WIDTH  - default operand width for both units
//   mult_state_e   - multiplier controller states (IDLE/RUN/DONE)
//   div_state_e    - divider controller states (IDLE/RUN/DONE)
//   cnt_width()    - width of an iteration counter that can hold 0..width
// ---------------------------------------------------------------------------
package arith_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // 2'b11 is deliberately left unnamed; both controllers treat it as
    // illegal and recover to IDLE.
    typedef enum logic [1:0] {
        MULT_IDLE = 2'b00,
        MULT_RUN  = 2'b01,
        MULT_DONE = 2'b10
    } mult_state_e;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_RUN  = 2'b01,
        DIV_DONE = 2'b10
    } div_state_e;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mult_controller.sv
// ---------------------------------------------------------------------------
// mult_controller
//
// Sequencing FSM and iteration counter for the shift-add multiplier. It
// decides when the datapath loads new operands, when it iterates, and when
// the product is final. The datapath itself lives in seq_multiplier.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous, active-low reset
//   start  - load operands and (re)start a multiply; wins in every state
//   p_lsb  - current LSB of the product/multiplier register
//   load   - datapath loads A and P this edge
//   add    - datapath adds A into the upper half this edge (RUN and P[0]=1)
//   shift  - datapath shifts P right this edge (every RUN iteration)
//   valid  - product is final (DONE state, one cycle)
//   busy   - iterating (RUN state)
// ---------------------------------------------------------------------------
module mult_controller
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic p_lsb,
    output logic load,
    output logic add,
    output logic shift,
    output logic valid,
    output logic busy
);

    localparam int                CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    mult_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= MULT_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // valid and busy are pure decodes of the current state, so they stay
    // correct even in the cycle where a new start is being accepted.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        add     = 1'b0;
        shift   = 1'b0;
        valid   = (state_q == MULT_DONE);
        busy    = (state_q == MULT_RUN);

        if (start) begin
            // A start abandons whatever was in progress.
            load    = 1'b1;
            cnt_d   = '0;
            state_d = MULT_RUN;
        end else begin
            case (state_q)
                MULT_IDLE: begin
                    state_d = MULT_IDLE;
                end
                MULT_RUN: begin
                    shift = 1'b1;
                    add   = p_lsb;
                    cnt_d = cnt_q + CNT_ONE;
                    // The edge that sees the last count performs the final
                    // iteration, so the product is ready in the next cycle.
                    if (cnt_q == LAST_CNT) begin
                        state_d = MULT_DONE;
                    end
                end
                MULT_DONE: begin
                    state_d = MULT_IDLE;
                end
                default: begin
                    state_d = MULT_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/seq_multiplier.sv
// ---------------------------------------------------------------------------
// seq_multiplier
//
// Unsigned shift-add multiplier, one multiplier bit per clock. P holds the
// running partial sum in its upper half and the not-yet-consumed multiplier
// bits in its lower half; each iteration optionally adds A into the upper
// half and then shifts the whole register right by one.
//
// Ports:
//   clk          - rising-edge clock
//   reset        - asynchronous, active-low reset
//   start        - sample operands and begin a multiply
//   multiplicand - operand A, sampled only when start is high
//   multiplier   - operand B, sampled only when start is high
//   product      - A*B (2*WIDTH bits); final while/after valid is high
//   valid        - one-cycle pulse when product is final
//   busy         - high while iterating
// ---------------------------------------------------------------------------
module seq_multiplier
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [2*WIDTH-1:0]   product,
    output logic                 valid,
    output logic                 busy
);

    logic [WIDTH-1:0]   a_q, a_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic [WIDTH:0]     sum;
    logic               load;
    logic               add;
    logic               shift;

    mult_controller #(
        .WIDTH (WIDTH)
    ) u_ctrl (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .p_lsb (p_q[0]),
        .load  (load),
        .add   (add),
        .shift (shift),
        .valid (valid),
        .busy  (busy)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q <= '0;
            p_q <= '0;
        end else begin
            a_q <= a_d;
            p_q <= p_d;
        end
    end

    // The adder is one bit wider than the operands: its carry becomes the
    // new MSB of P after the shift, which is what keeps (2^W-1)^2 exact.
    always_comb begin
        a_d = a_q;
        p_d = p_q;
        sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q};

        if (load) begin
            a_d = multiplicand;
            p_d = {{WIDTH{1'b0}}, multiplier};
        end else if (shift) begin
            if (add) begin
                p_d = {sum, p_q[WIDTH-1:1]};
            end else begin
                p_d = {1'b0, p_q[2*WIDTH-1:1]};
            end
        end
    end

    assign product = p_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// ---------------------------------------------------------------------------
// tb_seq_multiplier
//
// Self-checking bench for seq_multiplier at WIDTH=8 and WIDTH=4. Expected
// products come from plain integer multiplication; expected timing comes
// from the documented latency (WIDTH+1 cycles from start to valid).
// ---------------------------------------------------------------------------
module tb_seq_multiplier;

    localparam int W8  = 8;
    localparam int W4  = 4;
    localparam int LIM = 40;

    logic          clk;
    logic          reset;

    logic          start8;
    logic [7:0]    a8, b8;
    logic [15:0]   product8;
    logic          valid8, busy8;

    logic          start4;
    logic [3:0]    a4, b4;
    logic [7:0]    product4;
    logic          valid4, busy4;

    int            n_compared;
    int            n_mismatch;
    int            valid_seen8;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [6];

    seq_multiplier #(.WIDTH(W8)) dut8 (
        .clk          (clk),
        .reset        (reset),
        .start        (start8),
        .multiplicand (a8),
        .multiplier   (b8),
        .product      (product8),
        .valid        (valid8),
        .busy         (busy8)
    );

    seq_multiplier #(.WIDTH(W4)) dut4 (
        .clk          (clk),
        .reset        (reset),
        .start        (start4),
        .multiplicand (a4),
        .multiplier   (b4),
        .product      (product4),
        .valid        (valid4),
        .busy         (busy4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts every cycle in which the 8-bit unit reported valid, so
    // scenarios can check how many pulses occurred over a window.
    always @(posedge clk) begin
        if (valid8) valid_seen8 <= valid_seen8 + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatch++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Starts one multiply on the 8-bit unit and returns when valid is seen
    // (or the bound expires). lat counts cycles from start assertion to the
    // valid cycle; operands are scrambled while running since they are
    // don't-care after the start edge.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                 output int lat, output int busy_cnt);
        start8 = 1'b1;
        a8 = a;
        b8 = b;
        tick();
        start8 = 1'b0;
        lat = 1;
        busy_cnt = busy8 ? 1 : 0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        while (!valid8 && lat < LIM) begin
            tick();
            lat++;
            if (busy8) busy_cnt++;
            a8 = 8'($urandom);
            b8 = 8'($urandom);
        end
    endtask

    task automatic applyStimulus4(input logic [3:0] a, input logic [3:0] b,
                                  output int lat);
        start4 = 1'b1;
        a4 = a;
        b4 = b;
        tick();
        start4 = 1'b0;
        lat = 1;
        a4 = 4'($urandom);
        b4 = 4'($urandom);
        while (!valid4 && lat < LIM) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int busy_cnt;
        int seen;
        logic [7:0]  ra, rb;
        logic [3:0]  sa, sb;
        logic [15:0] exp16;

        n_compared  = 0;
        n_mismatch  = 0;
        valid_seen8 = 0;
        reset  = 1'b0;
        start8 = 1'b0;
        start4 = 1'b0;
        a8 = '0; b8 = '0;
        a4 = '0; b4 = '0;

        vecs[0] = '{a: 8'd13,  b: 8'd11,  exp: 16'd143};
        vecs[1] = '{a: 8'd255, b: 8'd255, exp: 16'd65025};
        vecs[2] = '{a: 8'd0,   b: 8'd200, exp: 16'd0};
        vecs[3] = '{a: 8'd200, b: 8'd1,   exp: 16'd200};
        vecs[4] = '{a: 8'd1,   b: 8'd255, exp: 16'd255};
        vecs[5] = '{a: 8'd128, b: 8'd2,   exp: 16'd256};

        // Reset state
        #2;
        checkOutput("reset_product", 32'(product8), 0);
        checkOutput("reset_valid", 32'(valid8), 0);
        checkOutput("reset_busy", 32'(busy8), 0);
        checkOutput("reset_product4", 32'(product4), 0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        checkOutput("post_reset_product", 32'(product8), 0);

        // Table-driven vectors
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, lat, busy_cnt);
            checkOutput($sformatf("vec%0d_product", i), 32'(product8), 32'(vecs[i].exp));
            checkOutput($sformatf("vec%0d_latency", i), lat, W8 + 1);
            checkOutput($sformatf("vec%0d_busy_cycles", i), busy_cnt, W8);
            tick();
            checkOutput($sformatf("vec%0d_valid_drop", i), 32'(valid8), 0);
            checkOutput($sformatf("vec%0d_hold", i), 32'(product8), 32'(vecs[i].exp));
            tick();
        end

        // Reset mid-operation after three RUN iterations
        start8 = 1'b1; a8 = 8'd13; b8 = 8'd11;
        tick();
        start8 = 1'b0;
        tick(); tick(); tick();
        #2 reset = 1'b0;
        #1;
        checkOutput("midreset_product", 32'(product8), 0);
        checkOutput("midreset_valid", 32'(valid8), 0);
        checkOutput("midreset_busy", 32'(busy8), 0);
        tick();
        reset = 1'b1;
        seen = valid_seen8;
        for (int i = 0; i < 15; i++) tick();
        checkOutput("midreset_no_valid", valid_seen8 - seen, 0);

        // Restart in the 4th RUN cycle
        seen = valid_seen8;
        start8 = 1'b1; a8 = 8'd100; b8 = 8'd100;
        tick();
        start8 = 1'b0;
        tick(); tick(); tick();
        applyStimulus(8'd7, 8'd6, lat, busy_cnt);
        checkOutput("restart_product", 32'(product8), 42);
        checkOutput("restart_latency", lat, W8 + 1);
        tick();
        checkOutput("restart_single_valid", valid_seen8 - seen, 1);

        // Start held for three cycles: iteration begins after the last one
        start8 = 1'b1; a8 = 8'd20; b8 = 8'd30;
        tick(); tick(); tick();
        checkOutput("held_busy", 32'(busy8), 1);
        applyStimulus(8'd21, 8'd31, lat, busy_cnt);
        checkOutput("held_product", 32'(product8), 651);
        checkOutput("held_latency", lat, W8 + 1);
        tick();

        // Back-to-back: second start issued in the valid cycle
        applyStimulus(8'd3, 8'd5, lat, busy_cnt);
        checkOutput("b2b_first_product", 32'(product8), 15);
        checkOutput("b2b_first_valid", 32'(valid8), 1);
        applyStimulus(8'd9, 8'd9, lat, busy_cnt);
        checkOutput("b2b_second_product", 32'(product8), 81);
        checkOutput("b2b_second_latency", lat, W8 + 1);
        tick(); tick(); tick();
        checkOutput("b2b_hold", 32'(product8), 81);
        checkOutput("b2b_valid_low", 32'(valid8), 0);

        // Random sweep against plain multiplication
        for (int i = 0; i < 1000; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) tick();
            ra = 8'($urandom);
            rb = 8'($urandom);
            exp16 = 16'(ra) * 16'(rb);
            applyStimulus(ra, rb, lat, busy_cnt);
            checkOutput($sformatf("rand%0d_%0dx%0d", i, ra, rb), 32'(product8), 32'(exp16));
            checkOutput($sformatf("rand%0d_latency", i), lat, W8 + 1);
        end
        tick();

        // WIDTH=4 instance
        applyStimulus4(4'd15, 4'd15, lat);
        checkOutput("w4_15x15", 32'(product4), 225);
        checkOutput("w4_latency", lat, W4 + 1);
        tick();
        checkOutput("w4_valid_drop", 32'(valid4), 0);
        for (int i = 0; i < 50; i++) begin
            sa = 4'($urandom);
            sb = 4'($urandom);
            applyStimulus4(sa, sb, lat);
            checkOutput($sformatf("w4_rand%0d_%0dx%0d", i, sa, sb), 32'(product4),
                        32'(8'(sa) * 8'(sb)));
            checkOutput($sformatf("w4_rand%0d_latency", i), lat, W4 + 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
